// File: rtl/eth_tx_arbiter.sv
// Round-robin scheduler sharing one Ethernet TX framing engine between NUM_REQ frame sources.
// Enforces the inter-frame gap, holds off new frames during 802.3x PAUSE and aborts hung frames.

module eth_tx_arbiter_chk #(
    parameter int NUM_REQ = 4
) (
    input logic               clk,
    input logic               rst,
    input logic [NUM_REQ-1:0] grant,
    input logic               eng_start,
    input logic               eng_abort,
    input logic               timeout_err,
    input logic               paused,
    input logic               busy
);
    a_grant_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(grant))
        else $error("grant is not one-hot");
    a_abort_pair: assert property (@(posedge clk) disable iff (rst) eng_abort == timeout_err)
        else $error("eng_abort and timeout_err disagree");
    a_start_owned: assert property (@(posedge clk) disable iff (rst)
        eng_start |-> (busy && (grant != {NUM_REQ{1'b0}})))
        else $error("eng_start without an owner");
    a_pause_quiet: assert property (@(posedge clk) disable iff (rst)
        paused |-> (!busy && (grant == {NUM_REQ{1'b0}})))
        else $error("paused while a frame is active");
endmodule

module eth_tx_arbiter #(
    parameter int NUM_REQ           = 4,
    parameter int IFG_CYCLES        = 12,
    parameter int MAX_FRAME_CYCLES  = 1530,
    parameter int PAUSE_QUANTUM_CYC = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       eng_start,
    input  logic                       eng_done,
    output logic                       eng_abort,
    input  logic                       pause_valid,
    input  logic [15:0]                pause_quanta,
    output logic                       paused,
    output logic                       busy,
    output logic                       timeout_err
);
    localparam int IDW = $clog2(NUM_REQ);
    localparam int PCW = 16 + $clog2(PAUSE_QUANTUM_CYC);
    localparam int FCW = $clog2(MAX_FRAME_CYCLES + 1);
    localparam int ICW = $clog2(IFG_CYCLES + 1);

    localparam logic [FCW-1:0]     FRAME_LAST = FCW'(MAX_FRAME_CYCLES - 1);
    localparam logic [ICW-1:0]     IFG_LAST   = ICW'(IFG_CYCLES - 1);
    localparam logic [PCW-1:0]     QUANTUM    = PCW'(PAUSE_QUANTUM_CYC);
    localparam logic [NUM_REQ-1:0] ONE_HOT0   = {{(NUM_REQ-1){1'b0}}, 1'b1};
    localparam logic [FCW-1:0]     FCNT_ONE   = {{(FCW-1){1'b0}}, 1'b1};
    localparam logic [ICW-1:0]     ICNT_ONE   = {{(ICW-1){1'b0}}, 1'b1};
    localparam logic [PCW-1:0]     PCNT_ONE   = {{(PCW-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_BUSY  = 3'd2,
        ST_IFG   = 3'd3,
        ST_PAUSE = 3'd4
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [NUM_REQ-1:0] grant_r;
    logic [NUM_REQ-1:0] grant_nxt_s;
    logic [IDW-1:0]     grant_id_r;
    logic [IDW-1:0]     grant_id_nxt_s;
    logic               eng_start_r;
    logic               eng_abort_r;
    logic               timeout_err_r;
    logic               paused_r;
    logic               busy_r;
    logic               abort_nxt_s;
    logic [FCW-1:0]     frame_cnt_r;
    logic [ICW-1:0]     ifg_cnt_r;
    logic [PCW-1:0]     pause_cnt_r;
    logic [PCW-1:0]     pause_cnt_nxt_s;
    logic [IDW:0]       pick_s;

    // Returns {found, index}: first requester after 'last' in circular order.
    function automatic logic [IDW:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                             input logic [IDW-1:0]     last);
        logic [IDW:0]   res;
        logic [IDW-1:0] idx;
        res = {1'b0, last};
        // Scanning from the farthest candidate lets the nearest one overwrite last.
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx = IDW'((int'(last) + i) % NUM_REQ);
            if (r[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Round-robin candidate for the next frame
    always_comb begin
        pick_s = rr_pick(req, grant_id_r);
    end

    // Pause counter: a new PAUSE frame always overrides the countdown
    always_comb begin
        pause_cnt_nxt_s = pause_cnt_r;
        if (pause_valid) begin
            pause_cnt_nxt_s = PCW'(pause_quanta) * QUANTUM;
        end else if ((state_r == ST_PAUSE) && (pause_cnt_r != {PCW{1'b0}})) begin
            pause_cnt_nxt_s = pause_cnt_r - PCNT_ONE;
        end else begin
            pause_cnt_nxt_s = pause_cnt_r;
        end
    end

    // Next-state, grant and abort decode
    always_comb begin
        state_nxt_s    = state_r;
        grant_nxt_s    = grant_r;
        grant_id_nxt_s = grant_id_r;
        abort_nxt_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (pause_cnt_r != {PCW{1'b0}}) begin
                    state_nxt_s = ST_PAUSE;
                end else if (pick_s[IDW]) begin
                    state_nxt_s    = ST_START;
                    grant_nxt_s    = ONE_HOT0 << pick_s[IDW-1:0];
                    grant_id_nxt_s = pick_s[IDW-1:0];
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_START: begin
                state_nxt_s = ST_BUSY;
            end
            ST_BUSY: begin
                // A completion in the watchdog's last cycle still counts as a clean frame.
                if (eng_done) begin
                    state_nxt_s = ST_IFG;
                    grant_nxt_s = {NUM_REQ{1'b0}};
                end else if (frame_cnt_r == FRAME_LAST) begin
                    state_nxt_s = ST_IFG;
                    grant_nxt_s = {NUM_REQ{1'b0}};
                    abort_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = ST_BUSY;
                end
            end
            ST_IFG: begin
                if (ifg_cnt_r == IFG_LAST) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_IFG;
                end
            end
            ST_PAUSE: begin
                if (pause_cnt_nxt_s == {PCW{1'b0}}) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_PAUSE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                grant_nxt_s = {NUM_REQ{1'b0}};
            end
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            grant_r       <= {NUM_REQ{1'b0}};
            grant_id_r    <= IDW'(NUM_REQ - 1);
            eng_start_r   <= 1'b0;
            eng_abort_r   <= 1'b0;
            timeout_err_r <= 1'b0;
            paused_r      <= 1'b0;
            busy_r        <= 1'b0;
            frame_cnt_r   <= {FCW{1'b0}};
            ifg_cnt_r     <= {ICW{1'b0}};
            pause_cnt_r   <= {PCW{1'b0}};
        end else begin
            state_r       <= state_nxt_s;
            grant_r       <= grant_nxt_s;
            grant_id_r    <= grant_id_nxt_s;
            eng_start_r   <= (state_nxt_s == ST_START);
            eng_abort_r   <= abort_nxt_s;
            timeout_err_r <= abort_nxt_s;
            paused_r      <= (state_nxt_s == ST_PAUSE);
            busy_r        <= (state_nxt_s == ST_START) || (state_nxt_s == ST_BUSY) ||
                             (state_nxt_s == ST_IFG);
            pause_cnt_r   <= pause_cnt_nxt_s;
            // Frame age is 0 in the START cycle, so the watchdog counts from eng_start.
            if ((state_r == ST_START) || (state_r == ST_BUSY)) begin
                frame_cnt_r <= frame_cnt_r + FCNT_ONE;
            end else begin
                frame_cnt_r <= {FCW{1'b0}};
            end
            if (state_r == ST_IFG) begin
                ifg_cnt_r <= ifg_cnt_r + ICNT_ONE;
            end else begin
                ifg_cnt_r <= {ICW{1'b0}};
            end
        end
    end

    assign grant       = grant_r;
    assign grant_id    = grant_id_r;
    assign eng_start   = eng_start_r;
    assign eng_abort   = eng_abort_r;
    assign timeout_err = timeout_err_r;
    assign paused      = paused_r;
    assign busy        = busy_r;

    eth_tx_arbiter_chk #(
        .NUM_REQ (NUM_REQ)
    ) u_chk (
        .clk         (clk),
        .rst         (rst),
        .grant       (grant_r),
        .eng_start   (eng_start_r),
        .eng_abort   (eng_abort_r),
        .timeout_err (timeout_err_r),
        .paused      (paused_r),
        .busy        (busy_r)
    );
endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Self-checking bench for eth_tx_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a timestamp-style reference model.

module tb_eth_tx_arbiter;
    localparam int NUM_REQ           = 4;
    localparam int IFG_CYCLES        = 12;
    localparam int MAX_FRAME_CYCLES  = 1530;
    localparam int PAUSE_QUANTUM_CYC = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  grant;
    logic [1:0]  grant_id;
    logic        eng_start;
    logic        eng_done;
    logic        eng_abort;
    logic        pause_valid;
    logic [15:0] pause_quanta;
    logic        paused;
    logic        busy;
    logic        timeout_err;

    eth_tx_arbiter #(
        .NUM_REQ           (NUM_REQ),
        .IFG_CYCLES        (IFG_CYCLES),
        .MAX_FRAME_CYCLES  (MAX_FRAME_CYCLES),
        .PAUSE_QUANTUM_CYC (PAUSE_QUANTUM_CYC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .grant        (grant),
        .grant_id     (grant_id),
        .eng_start    (eng_start),
        .eng_done     (eng_done),
        .eng_abort    (eng_abort),
        .pause_valid  (pause_valid),
        .pause_quanta (pause_quanta),
        .paused       (paused),
        .busy         (busy),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Reference model: who owns the engine, frame age, remaining gap and pause budget.
    int m_owner;
    int m_last;
    int m_age;
    int m_gap;
    int m_pause_left;
    bit m_pausing;
    bit e_start;
    bit e_abort;

    int frame_len;
    int fixed_len;
    bit spurious_en;

    int start_ids[$];
    int start_cyc;
    int abort_cyc;
    int paused_cycles;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h required %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_owner      = -1;
        m_last       = NUM_REQ - 1;
        m_age        = 0;
        m_gap        = 0;
        m_pause_left = 0;
        m_pausing    = 1'b0;
        e_start      = 1'b0;
        e_abort      = 1'b0;
    endtask

    task automatic model_step();
        int new_pause;
        int c;
        e_start = 1'b0;
        e_abort = 1'b0;
        if (pause_valid)
            new_pause = int'(pause_quanta) * PAUSE_QUANTUM_CYC;
        else if (m_pausing && m_pause_left > 0)
            new_pause = m_pause_left - 1;
        else
            new_pause = m_pause_left;

        if (m_owner >= 0) begin
            if (m_age >= 1 && eng_done) begin
                m_owner = -1;
                m_gap   = IFG_CYCLES;
            end else if (m_age == MAX_FRAME_CYCLES - 1) begin
                m_owner = -1;
                m_gap   = IFG_CYCLES;
                e_abort = 1'b1;
            end else begin
                m_age++;
            end
        end else if (m_gap > 0) begin
            m_gap--;
        end else if (m_pausing) begin
            if (new_pause == 0) m_pausing = 1'b0;
        end else if (m_pause_left != 0) begin
            m_pausing = 1'b1;
        end else if (req != 4'b0000) begin
            for (int j = 1; j <= NUM_REQ; j++) begin
                c = (m_last + j) % NUM_REQ;
                if (req[c]) begin
                    m_owner = c;
                    break;
                end
            end
            m_last    = m_owner;
            m_age     = 0;
            e_start   = 1'b1;
            frame_len = (fixed_len > 0) ? fixed_len : int'($urandom_range(1, 40));
        end
        m_pause_left = new_pause;
    endtask

    task automatic compare_all();
        check_val("grant", grant, (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
        check_val("grant_id", grant_id, m_last);
        check_val("eng_start", eng_start, e_start);
        check_val("eng_abort", eng_abort, e_abort);
        check_val("timeout_err", timeout_err, e_abort);
        check_val("paused", paused, m_pausing);
        check_val("busy", busy, (m_owner >= 0) || (m_gap > 0));
        if (eng_start) begin
            start_ids.push_back(int'(grant_id));
            start_cyc = cyc;
        end
        if (eng_abort) abort_cyc = cyc;
        if (paused) paused_cycles++;
    endtask

    task automatic tick();
        if (m_owner >= 0)
            eng_done = (m_age == frame_len);
        else
            eng_done = spurious_en && ($urandom_range(0, 15) == 0);
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        compare_all();
        eng_done    = 1'b0;
        pause_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        req         = 4'b0000;
        pause_valid = 1'b0;
        eng_done    = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        rst = 1'b0;
    endtask

    initial begin
        fixed_len    = 20;
        spurious_en  = 1'b0;
        pause_quanta = 16'd0;
        start_cyc    = -1;
        abort_cyc    = -1;
        paused_cycles = 0;
        do_reset();

        // Single requester: grant and start one cycle after the request is sampled.
        fixed_len = 5;
        req = 4'b0001;
        tick();
        check_val("t1_grant", grant, 4'b0001);
        check_val("t1_start", eng_start, 1'b1);
        req = 4'b0000;
        repeat (25) tick();

        // All requesters: rotation 0,1,2,3,0 starting from reset.
        do_reset();
        fixed_len = 20;
        req = 4'b1111;
        start_ids.delete();
        repeat (150) tick();
        check_val("t2_nstarts", start_ids.size() >= 5, 1'b1);
        for (int k = 0; k < 5; k++)
            check_val("t2_order", (k < start_ids.size()) ? start_ids[k] : -1, k % NUM_REQ);
        req = 4'b0000;
        repeat (40) tick();

        // Watchdog: source 2 never completes.
        do_reset();
        fixed_len = 5;
        req = 4'b0010;
        tick();
        req = 4'b0000;
        repeat (25) tick();
        check_val("t3_id", grant_id, 2'd1);
        fixed_len = 100000;
        req = 4'b0100;
        start_cyc = -1;
        abort_cyc = -1;
        tick();
        req = 4'b0000;
        repeat (1545) tick();
        check_val("t3_delay", abort_cyc - start_cyc, MAX_FRAME_CYCLES);

        // PAUSE during a frame: frame and gap complete, then 3 quanta of pause.
        do_reset();
        fixed_len = 30;
        req = 4'b0001;
        paused_cycles = 0;
        repeat (5) tick();
        pause_valid  = 1'b1;
        pause_quanta = 16'd3;
        tick();
        repeat (260) tick();
        check_val("t4_pause_len", paused_cycles, 3 * PAUSE_QUANTUM_CYC);
        req = 4'b0000;
        repeat (40) tick();

        // Zero-quanta PAUSE cancels the pause; pending request granted next.
        do_reset();
        fixed_len = 8;
        pause_valid  = 1'b1;
        pause_quanta = 16'd10;
        tick();
        repeat (4) tick();
        check_val("t5_paused", paused, 1'b1);
        req = 4'b0100;
        pause_valid  = 1'b1;
        pause_quanta = 16'd0;
        tick();
        check_val("t5_unpaused", paused, 1'b0);
        tick();
        check_val("t5_grant", grant, 4'b0100);
        req = 4'b0000;
        repeat (30) tick();

        // Asynchronous reset mid-frame drops the grant without an abort.
        do_reset();
        fixed_len = 50;
        req = 4'b0001;
        repeat (10) tick();
        check_val("t6_busy_pre", busy, 1'b1);
        #2 rst = 1'b1;
        #1;
        check_val("t6_grant", grant, 4'b0000);
        check_val("t6_busy", busy, 1'b0);
        check_val("t6_abort", eng_abort, 1'b0);
        model_reset();
        req = 4'b0000;
        @(posedge clk);
        #1;
        compare_all();
        rst = 1'b0;

        // Randomized traffic with spurious completions and occasional PAUSE frames.
        do_reset();
        fixed_len   = 0;
        spurious_en = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 149) == 0) begin
                pause_valid  = 1'b1;
                pause_quanta = 16'($urandom_range(0, 3));
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
